// File: rtl/dram_responder_pkg.sv
// Shared types and default parameters for the DRAM-to-SRAM responder.
package dram_responder_pkg;

  localparam int ADDR_W_DEF      = 8;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int ACCESS_CYC_DEF  = 2;
  localparam int WR_CYC_DEF      = 2;

  typedef enum logic [2:0] {
    IDLE,
    ROW_OPEN,
    RD_WAIT,
    RD_DRIVE,
    WR_PULSE,
    COL_HOLD
  } state_t;

endpackage

// File: rtl/dram_responder_strobe_sync.sv
// Preset-high synchroniser for one active-low strobe, with single-cycle
// fall/rise pulses derived from the synchronised level.
module strobe_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic fall,
  output logic rise
);

  logic [STAGES-1:0] chain;
  logic              prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '1;
      prev  <= 1'b1;
    end else begin
      chain[0] <= din;
      for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
      prev <= chain[STAGES-1];
    end
  end

  assign level = chain[STAGES-1];
  assign fall  = prev & ~level;
  assign rise  = ~prev & level;

endmodule

// File: rtl/dram_responder.sv
// Emulates a multiplexed-address DRAM bank on top of an async SRAM: row on
// RAS fall, column on each CAS fall, one SRAM read or write per CAS cycle.
module dram_responder
  import dram_responder_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int ACCESS_CYC  = ACCESS_CYC_DEF,
  parameter int WR_CYC      = WR_CYC_DEF
) (
  input  logic                  CLK_n,
  input  logic                  RESET_n,
  input  logic                  RAS_n,
  input  logic                  CAS_n,
  input  logic                  WE_n,
  input  logic [ADDR_W-1:0]     MA,
  input  logic [7:0]            D_IN,
  output logic [7:0]            D_OUT,
  output logic                  D_OE,
  output logic [2*ADDR_W-1:0]   SRAM_A,
  input  logic [7:0]            SRAM_DQ_IN,
  output logic [7:0]            SRAM_DQ_OUT,
  output logic                  SRAM_OE_n,
  output logic                  SRAM_WE_n,
  output logic                  TIMING_ERR
);

  localparam logic [7:0] ACC_LAST = 8'(ACCESS_CYC - 1);
  localparam logic [7:0] WR_LAST  = 8'(WR_CYC - 1);

  logic ras_lvl, ras_fall, ras_rise;
  logic cas_lvl, cas_fall, cas_rise;
  logic we_lvl;

  strobe_sync #(.STAGES(SYNC_STAGES)) u_ras_sync (
    .clk(CLK_n), .rst_n(RESET_n), .din(RAS_n),
    .level(ras_lvl), .fall(ras_fall), .rise(ras_rise)
  );

  strobe_sync #(.STAGES(SYNC_STAGES)) u_cas_sync (
    .clk(CLK_n), .rst_n(RESET_n), .din(CAS_n),
    .level(cas_lvl), .fall(cas_fall), .rise(cas_rise)
  );

  strobe_sync #(.STAGES(SYNC_STAGES)) u_we_sync (
    .clk(CLK_n), .rst_n(RESET_n), .din(WE_n),
    .level(we_lvl), .fall(), .rise()
  );

  state_t                state, state_nx;
  logic [ADDR_W-1:0]     row, row_nx;
  logic [7:0]            cnt, cnt_nx;
  logic [2*ADDR_W-1:0]   sram_a_nx;
  logic [7:0]            dq_out_nx, d_out_nx;
  logic                  oe_n_nx, we_n_nx, d_oe_nx, err_nx;

  always_comb begin
    state_nx  = state;
    row_nx    = row;
    cnt_nx    = cnt;
    sram_a_nx = SRAM_A;
    dq_out_nx = SRAM_DQ_OUT;
    d_out_nx  = D_OUT;
    oe_n_nx   = SRAM_OE_n;
    we_n_nx   = SRAM_WE_n;
    d_oe_nx   = D_OE;
    err_nx    = TIMING_ERR;

    case (state)
      IDLE: begin
        // A CAS fall here, even together with RAS, is CAS-before-RAS.
        if (cas_fall) begin
          err_nx = 1'b1;
        end else if (ras_fall) begin
          row_nx   = MA;
          state_nx = ROW_OPEN;
        end
      end

      ROW_OPEN: begin
        if (ras_rise) begin
          state_nx = IDLE;
          if (cas_fall) err_nx = 1'b1;
        end else if (cas_fall) begin
          sram_a_nx = {row, MA};
          cnt_nx    = 8'd0;
          if (!we_lvl) begin
            dq_out_nx = D_IN;
            we_n_nx   = 1'b0;
            state_nx  = WR_PULSE;
          end else begin
            oe_n_nx  = 1'b0;
            state_nx = RD_WAIT;
          end
        end
      end

      RD_WAIT: begin
        // Any strobe rise before data capture is a premature end of cycle.
        if (ras_rise || cas_rise) begin
          oe_n_nx  = 1'b1;
          d_oe_nx  = 1'b0;
          err_nx   = 1'b1;
          state_nx = ras_rise ? IDLE : ROW_OPEN;
        end else if (cnt == ACC_LAST) begin
          d_out_nx = SRAM_DQ_IN;
          d_oe_nx  = 1'b1;
          oe_n_nx  = 1'b1;
          state_nx = RD_DRIVE;
        end else begin
          cnt_nx = cnt + 8'd1;
        end
      end

      RD_DRIVE: begin
        if (ras_rise) begin
          d_oe_nx  = 1'b0;
          state_nx = IDLE;
          if (!cas_lvl) err_nx = 1'b1;
        end else if (cas_rise) begin
          d_oe_nx  = 1'b0;
          state_nx = ROW_OPEN;
        end
      end

      WR_PULSE: begin
        // The pulse always runs its full width; strobe levels pick the exit.
        if (ras_rise && !cas_lvl) err_nx = 1'b1;
        if (cnt == WR_LAST) begin
          we_n_nx = 1'b1;
          if (ras_lvl)      state_nx = IDLE;
          else if (cas_lvl) state_nx = ROW_OPEN;
          else              state_nx = COL_HOLD;
        end else begin
          cnt_nx = cnt + 8'd1;
        end
      end

      COL_HOLD: begin
        if (ras_rise) begin
          state_nx = IDLE;
          if (!cas_lvl) err_nx = 1'b1;
        end else if (cas_rise) begin
          state_nx = ROW_OPEN;
        end
      end

      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK_n or negedge RESET_n) begin
    if (!RESET_n) begin
      state       <= IDLE;
      cnt         <= 8'd0;
      SRAM_A      <= '0;
      SRAM_DQ_OUT <= 8'd0;
      D_OUT       <= 8'd0;
      SRAM_OE_n   <= 1'b1;
      SRAM_WE_n   <= 1'b1;
      D_OE        <= 1'b0;
      TIMING_ERR  <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      SRAM_A      <= sram_a_nx;
      SRAM_DQ_OUT <= dq_out_nx;
      D_OUT       <= d_out_nx;
      SRAM_OE_n   <= oe_n_nx;
      SRAM_WE_n   <= we_n_nx;
      D_OE        <= d_oe_nx;
      TIMING_ERR  <= err_nx;
    end
  end

  // The latched row is only meaningful after a RAS fall, so it needs no reset.
  always_ff @(posedge CLK_n) begin
    row <= row_nx;
  end

endmodule

// File: doc/dram_responder.md
Name: dram_responder

Overview:
FPGA-side emulation of the 4164-style DRAM bank that consumes the multiplexed RAS_n/CAS_n/WE_n/MA strobes produced by the gate array's RAS/CAS generation. It latches the row on RAS fall and the column on each CAS fall, then converts each access into a single-cycle-addressed async SRAM read or write. On reads it returns data to the bus while CAS_n is held low. It lets the board run with one SRAM in place of the DRAM array.

Parameters:
ADDR_W, 8, row/column width; the SRAM address is 2*ADDR_W bits.
SYNC_STAGES, 2, synchroniser depth on RAS_n, CAS_n and WE_n.
ACCESS_CYC, 2, CLK_n cycles from SRAM_OE_n low to read data capture.
WR_CYC, 2, width of the SRAM_WE_n low pulse, in cycles.

Ports:
CLK_n  in  1  master clock; all logic on the rising edge.
RESET_n  in  1  async active-low reset.
RAS_n  in  1  row strobe from the gate array.
CAS_n  in  1  column strobe from the gate array.
WE_n  in  1  DRAM write enable.
MA  in  ADDR_W  multiplexed row/column address.
D_IN  in  8  write data from the bus.
D_OUT  out  8  read data to the bus.
D_OE  out  1  D_OUT valid/drive enable.
SRAM_A  out  2*ADDR_W  SRAM address {row,col}.
SRAM_DQ_IN  in  8  SRAM read data.
SRAM_DQ_OUT  out  8  SRAM write data.
SRAM_OE_n  out  1  SRAM output enable.
SRAM_WE_n  out  1  SRAM write strobe.
TIMING_ERR  out  1  sticky protocol-violation flag.

Behaviour:
- Reset (async, RESET_n=0): state IDLE; D_OE=0, D_OUT=0, SRAM_OE_n=1, SRAM_WE_n=1, SRAM_A=0, SRAM_DQ_OUT=0, TIMING_ERR=0. Synchronisers preset to 1 (inactive).
- RAS_n, CAS_n and WE_n pass through SYNC_STAGES flops. Edges are detected on the synchronised values. MA and D_IN are sampled raw on the edge where the synchronised fall is detected.
- States: IDLE, ROW_OPEN, RD_WAIT, RD_DRIVE, WR_PULSE, COL_HOLD.
- IDLE:
  - RAS fall -> latch row=MA; go to ROW_OPEN.
  - CAS fall while RAS_n high (CAS-before-RAS) -> set TIMING_ERR; stay in IDLE.
- ROW_OPEN, on CAS fall:
  - Latch col=MA and set SRAM_A={row,col}.
  - If synchronised WE_n=0: SRAM_DQ_OUT=D_IN, SRAM_WE_n=0 next cycle, go to WR_PULSE.
  - Else: SRAM_OE_n=0 next cycle, go to RD_WAIT.
- ROW_OPEN, on RAS rise with no CAS: RAS-only refresh. No SRAM strobes; go to IDLE.
- RD_WAIT: count ACCESS_CYC cycles, then D_OUT=SRAM_DQ_IN, D_OE=1, SRAM_OE_n=1, go to RD_DRIVE. CAS rise before the count completes -> TIMING_ERR=1, SRAM_OE_n=1, D_OE stays 0, go to ROW_OPEN.
- RD_DRIVE: hold D_OE=1 and D_OUT until CAS rise. Then D_OE=0 on the same cycle; go to ROW_OPEN.
- WR_PULSE: SRAM_WE_n low for exactly WR_CYC cycles, then high. Go to COL_HOLD, or to ROW_OPEN if CAS has already risen. CAS rise mid-pulse does not shorten the pulse.
- COL_HOLD: wait for CAS rise, then go to ROW_OPEN.
- Page mode: any number of CAS cycles per RAS reuse the latched row.
- RAS rise in any state other than IDLE/ROW_OPEN:
  - Abort: SRAM_OE_n=1, D_OE=0, go to IDLE.
  - A write pulse already started completes its WR_CYC cycles first.
  - If CAS is still low, set TIMING_ERR.
- Simultaneous RAS fall and CAS fall in the same detect cycle: treated as CAS-before-RAS; TIMING_ERR set.
- TIMING_ERR clears only on reset.

Decomposition:
- Shared package: state enum, ADDR_W default, the SYNC_STAGES/ACCESS_CYC/WR_CYC defaults.
- One sub-module: strobe_sync (parameterised-depth synchroniser, preset-high, with fall/rise pulse outputs), instantiated for RAS_n, CAS_n and WE_n.

Test Plan:
- Read: RAS fall with MA=0x12, CAS fall with MA=0x34, WE_n=1, SRAM_DQ_IN=0xA5 -> SRAM_A=0x1234, SRAM_OE_n low for 2 cycles, then D_OUT=0xA5 with D_OE=1 until CAS_n rises; TIMING_ERR=0.
- Write: row 0x7F, col 0x00, WE_n=0, D_IN=0x3C -> SRAM_A=0x7F00, SRAM_DQ_OUT=0x3C, SRAM_WE_n low exactly 2 cycles, D_OE never asserted.
- Page mode: one RAS (row 0xC0), two CAS reads (cols 0x10, 0x11) -> SRAM_A 0xC010 then 0xC011; two D_OE windows; row not relatched.
- RAS-only refresh (row 0x05, no CAS) -> no SRAM_OE_n/SRAM_WE_n activity; state back in IDLE. A following CAS-before-RAS -> TIMING_ERR=1 and stays 1.
- Early CAS rise: CAS_n high 1 cycle after its detected fall -> no D_OE, TIMING_ERR=1, next normal access still serviced.
- RESET_n pulsed low during RD_DRIVE -> D_OE=0, SRAM_OE_n=1 immediately (async); after release, a fresh read at 0x0102 completes normally.
